// File: rtl/seq_muldiv_ctrl.sv
// rtl/seq_muldiv_ctrl.sv - multi-cycle unsigned multiply/divide sequencer sharing one adder
module seq_muldiv_ctrl #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [n-1:0] opa,
    input  logic [n-1:0] opb,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PREP = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam int CW = $clog2(n);

    logic [1:0]    state;
    logic [1:0]    op_q;
    logic [n-1:0]  opb_q;
    logic [n-1:0]  lo;
    logic [n-1:0]  result_q;
    logic [n:0]    acc;
    logic [n:0]    negd;
    logic [n:0]    shifted;
    logic [n:0]    add_a;
    logic [n:0]    add_b;
    logic [n:0]    sum;
    logic [CW-1:0] cnt;
    logic [n-1:0]  done_val;

    assign shifted = {acc[n-1:0], lo[n-1]};

    // The single shared adder: divisor negation in PREP, then add or trial-subtract in RUN.
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (state == PREP) begin
            // (n+1)-bit two's complement of the zero-extended divisor; zero stays zero.
            add_a = {1'b1, ~opb_q};
            add_b = {{n{1'b0}}, 1'b1};
        end else if (op_q[1]) begin
            add_a = shifted;
            add_b = negd;
        end else begin
            add_a = acc;
            add_b = lo[0] ? {1'b0, opb_q} : '0;
        end
    end

    assign sum = add_a + add_b;

    assign done_val = op_q[0] ? acc[n-1:0] : lo;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign result   = (state == DONE) ? done_val : result_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op_q     <= '0;
            opb_q    <= '0;
            lo       <= '0;
            acc      <= '0;
            negd     <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        opb_q <= opb;
                        lo    <= opa;
                        state <= PREP;
                    end
                end
                PREP: begin
                    negd  <= sum;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (!op_q[1]) begin
                        acc <= {1'b0, sum[n:1]};
                        lo  <= {sum[0], lo[n-1:1]};
                    end else if (!sum[n]) begin
                        acc <= sum;
                        lo  <= {lo[n-2:0], 1'b1};
                    end else begin
                        acc <= shifted;
                        lo  <= {lo[n-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(n - 1)) begin
                        state <= DONE;
                    end
                end
                default: begin
                    result_q <= done_val;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_muldiv_ctrl.sv
// tb/tb_seq_muldiv_ctrl.sv - self-checking bench for seq_muldiv_ctrl at n=8
module tb_seq_muldiv_ctrl;

    localparam int N   = 8;
    localparam int LAT = N + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] opa = '0;
    logic [N-1:0] opb = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp;
    } vec_t;

    vec_t tbl[7];

    seq_muldiv_ctrl #(.n(N)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .opa(opa),
        .opb(opb),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_model(input logic [1:0] o, input logic [N-1:0] a,
                                               input logic [N-1:0] b);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        case (o)
            2'b00:   return p[N-1:0];
            2'b01:   return p[2*N-1:N];
            2'b10:   return (b == 0) ? {N{1'b1}} : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issues one request and returns at the negedge where done is seen; lat counts negedges from accept.
    task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] res, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); opa = N'($urandom); opb = N'($urandom);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        res = result;
    endtask

    initial begin
        logic [N-1:0] res;
        logic [N-1:0] exp;
        logic [1:0]   ro;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        int lat;
        int dc;

        tbl[0] = '{2'b00, 8'd13,  8'd11, 8'h8F};
        tbl[1] = '{2'b01, 8'hFF,  8'hFF, 8'hFE};
        tbl[2] = '{2'b00, 8'hFF,  8'hFF, 8'h01};
        tbl[3] = '{2'b10, 8'd200, 8'd7,  8'h1C};
        tbl[4] = '{2'b11, 8'd200, 8'd7,  8'h04};
        tbl[5] = '{2'b10, 8'h5A,  8'h00, 8'hFF};
        tbl[6] = '{2'b11, 8'h5A,  8'h00, 8'h5A};

        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
            check($sformatf("tbl%0d_result", i), res, tbl[i].exp);
            check($sformatf("tbl%0d_latency", i), lat, LAT);
            @(negedge clk);
            check($sformatf("tbl%0d_hold", i), result, tbl[i].exp);
            check($sformatf("tbl%0d_done_pulse", i), done, 0);
        end

        // DIVU then REMU with the second start in the first cycle after done.
        run_op(2'b10, 8'd200, 8'd7, res, lat);
        check("b2b_divu", res, 8'h1C);
        run_op(2'b11, 8'd200, 8'd7, res, lat);
        check("b2b_remu", res, 8'h04);
        check("b2b_remu_latency", lat, LAT);

        // A start raised during the done cycle must be ignored.
        start = 1'b1; op = 2'b00; opa = 8'd3; opb = 8'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored", busy, 0);
        check("start_in_done_result", result, 8'h04);

        // Start while busy: the extra request is dropped.
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1; op = 2'b00; opa = 8'd13; opb = 8'd11;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (3) begin @(negedge clk); lat++; end
        start = 1'b1; op = 2'b00; opa = 8'd3; opb = 8'd3;
        @(negedge clk); lat++;
        start = 1'b0;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        check("busy_start_result", result, 8'h8F);
        check("busy_start_latency", lat, LAT);
        repeat (20) @(negedge clk);
        check("busy_start_one_done", done_cnt - dc, 1);
        check("busy_start_idle", busy, 0);

        // Reset in RUN with cnt=4 aborts asynchronously.
        @(negedge clk);
        start = 1'b1; op = 2'b00; opa = 8'd13; opb = 8'd11;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        dc = done_cnt;
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("midrst_no_done", done_cnt - dc, 0);
        run_op(2'b00, 8'd2, 8'd3, res, lat);
        check("post_rst_mul", res, 8'h06);
        check("post_rst_latency", lat, LAT);

        for (int k = 0; k < 40; k++) begin
            ro = 2'($urandom);
            ra = N'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
            exp = ref_model(ro, ra, rb);
            run_op(ro, ra, rb, res, lat);
            check($sformatf("rnd%0d_op%0d_%0h_%0h", k, ro, ra, rb), res, exp);
            check($sformatf("rnd%0d_latency", k), lat, LAT);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
